// File: rtl/char_motion.sv
// Per-frame position controller for the player sprite: horizontal walking with
// edge clamping and a three-state jump/fall model driven by a simple gravity step.
module char_motion #(
  parameter int SCREEN_W = 640,
  parameter int SPRITE   = 16,
  parameter int START_X  = 312,
  parameter int GROUND_Y = 448,
  parameter int STEP     = 2,
  parameter int JUMP_V   = 8,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] char_x,
  output logic [8:0] char_y,
  output logic       airborne,
  output logic       facing_left
);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] X_MAX    = 11'(SCREEN_W - SPRITE);
  localparam logic [8:0]  Y_GROUND = 9'(GROUND_Y);
  localparam logic [3:0]  V_JUMP   = 4'(JUMP_V);
  localparam logic [3:0]  V_GRAV   = 4'(GRAVITY);
  localparam logic [4:0]  V_MAX    = 5'(MAX_FALL);

  state_t      state_reg, state_next;
  logic [9:0]  x_reg, x_next;
  logic [8:0]  y_reg, y_next;
  logic [3:0]  vy_reg, vy_next;
  logic        face_reg, face_next;
  logic        jump_prev_reg;
  logic        jump_req_reg, jump_req_next;

  logic        jump_edge;
  logic        jump_active;
  logic [10:0] x_wide;
  logic [4:0]  vy_inc;
  logic [3:0]  vy_fall;
  logic [9:0]  ny;

  always_comb begin
    jump_edge   = btn_jump & ~jump_prev_reg;
    jump_active = jump_req_reg | jump_edge;
    x_wide      = {1'b0, x_reg};
    vy_inc      = {1'b0, vy_reg} + {1'b0, V_GRAV};
    vy_fall     = (vy_inc >= V_MAX) ? V_MAX[3:0] : vy_inc[3:0];
    ny          = {1'b0, y_reg} + {6'd0, vy_fall};

    // The request lives for at most one frame; an edge on the tick cycle is
    // consumed by jump_active before the clear takes effect.
    jump_req_next = frame_tick ? 1'b0 : (jump_req_reg | jump_edge);

    x_next     = x_reg;
    face_next  = face_reg;
    y_next     = y_reg;
    vy_next    = vy_reg;
    state_next = state_reg;

    if (frame_tick) begin
      if (btn_left && !btn_right) begin
        x_next    = (x_wide >= STEP_W) ? 10'(x_wide - STEP_W) : 10'd0;
        face_next = 1'b1;
      end else if (btn_right && !btn_left) begin
        x_next    = (x_wide + STEP_W >= X_MAX) ? X_MAX[9:0] : 10'(x_wide + STEP_W);
        face_next = 1'b0;
      end

      case (state_reg)
        GROUNDED: begin
          if (jump_active) begin
            state_next = RISING;
            vy_next    = V_JUMP;
          end else begin
            y_next = Y_GROUND;
          end
        end
        RISING: begin
          if (y_reg >= {5'd0, vy_reg}) begin
            y_next  = y_reg - {5'd0, vy_reg};
            // Saturate at zero so a GRAVITY larger than the remaining speed still tops out.
            vy_next = (vy_reg <= V_GRAV) ? 4'd0 : vy_reg - V_GRAV;
            if (vy_reg <= V_GRAV) state_next = FALLING;
          end else begin
            y_next     = 9'd0;
            vy_next    = 4'd0;
            state_next = FALLING;
          end
        end
        FALLING: begin
          if (ny >= {1'b0, Y_GROUND}) begin
            y_next     = Y_GROUND;
            vy_next    = 4'd0;
            state_next = GROUNDED;
          end else begin
            y_next  = ny[8:0];
            vy_next = vy_fall;
          end
        end
        default: state_next = GROUNDED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= GROUNDED;
      x_reg         <= 10'(START_X);
      y_reg         <= Y_GROUND;
      vy_reg        <= 4'd0;
      face_reg      <= 1'b0;
      jump_prev_reg <= 1'b0;
      jump_req_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      vy_reg        <= vy_next;
      face_reg      <= face_next;
      jump_prev_reg <= btn_jump;
      jump_req_reg  <= jump_req_next;
    end
  end

  assign char_x      = x_reg;
  assign char_y      = y_reg;
  assign airborne    = (state_reg != GROUNDED);
  assign facing_left = face_reg;

endmodule

// File: tb/tb_char_motion.sv
// Self-checking bench for char_motion: expected positions are queued as each frame
// tick is driven and compared once the edge that samples the tick has passed.
module tb_char_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       btn_left, btn_right, btn_jump;
  logic [9:0] char_x;
  logic [8:0] char_y;
  logic       airborne, facing_left;

  char_motion dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_jump   (btn_jump),
    .char_x     (char_x),
    .char_y     (char_y),
    .airborne   (airborne),
    .facing_left(facing_left)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    x;
    int    y;
    logic  air;
    logic  face;
  } exp_t;

  typedef struct {
    logic l;
    logic r;
    logic j;
    int   x;
    int   y;
    logic air;
    logic face;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ex_x   = 312;
  logic ex_face = 1'b0;

  // Default jump profile: index 0 is the tick that enters RISING.
  int prof[17] = '{448, 440, 433, 427, 422, 418, 415, 413, 412,
                   413, 415, 418, 422, 427, 433, 440, 448};

  task automatic push_exp(input string nm, input int x, input int y,
                          input logic air, input logic face);
    exp_t e;
    e.nm = nm; e.x = x; e.y = y; e.air = air; e.face = face;
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty: got nothing queued required one entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (int'(char_x) != e.x || int'(char_y) != e.y ||
        airborne !== e.air || facing_left !== e.face) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d air=%0b face=%0b required x=%0d y=%0d air=%0b face=%0b",
               e.nm, char_x, char_y, airborne, facing_left, e.x, e.y, e.air, e.face);
    end else begin
      $display("ok   %s: x=%0d y=%0d air=%0b face=%0b", e.nm, char_x, char_y, airborne, facing_left);
    end
  endtask

  // One frame: buttons and tick driven together, result checked after the edge,
  // then a quiet cycle with the same button levels.
  task automatic tick(input logic l, input logic r, input logic j, input string nm,
                      input int x, input int y, input logic air, input logic face);
    btn_left = l; btn_right = r; btn_jump = j; frame_tick = 1'b1;
    push_exp(nm, x, y, air, face);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    compare_front();
    @(posedge clk); #1;
  endtask

  task automatic step(input logic l, input logic r, input logic j, input string nm,
                      input int y, input logic air);
    if (l && !r) begin
      ex_x    = (ex_x >= 2) ? ex_x - 2 : 0;
      ex_face = 1'b1;
    end else if (r && !l) begin
      ex_x    = (ex_x + 2 > 624) ? 624 : ex_x + 2;
      ex_face = 1'b0;
    end
    tick(l, r, j, nm, ex_x, y, air, ex_face);
  endtask

  task automatic pulse_jump();
    btn_jump = 1'b1;
    @(posedge clk); #1;
    btn_jump = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tab[17];
    for (int k = 0; k < 17; k++) begin
      tab[k].l    = 1'b0;
      tab[k].r    = 1'b1;
      tab[k].j    = (k == 0);
      tab[k].x    = 2 * (k + 1);
      tab[k].y    = prof[k];
      tab[k].air  = (k < 16);
      tab[k].face = 1'b0;
    end

    reset = 1'b1; frame_tick = 1'b0;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    push_exp("reset_state", 312, 448, 1'b0, 1'b0);
    compare_front();
    reset = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 10; n++) step(0, 0, 0, "idle", 448, 1'b0);
    for (int n = 0; n < 200; n++) step(0, 1, 0, "walk_right", 448, 1'b0);
    for (int n = 0; n < 400; n++) step(1, 0, 0, "walk_left", 448, 1'b0);
    for (int n = 0; n < 5; n++) step(1, 1, 0, "both_buttons", 448, 1'b0);

    // Jump from a one-cycle pulse between ticks.
    pulse_jump();
    for (int k = 0; k < 17; k++) step(0, 0, 0, "jump_pulse", prof[k], k < 16);
    for (int n = 0; n < 3; n++) step(0, 0, 0, "after_pulse", 448, 1'b0);

    // Held button: the edge lands on T0, later ticks must not re-trigger.
    for (int k = 0; k < 17; k++) step(0, 0, 1, "jump_hold", prof[k], k < 16);
    for (int n = 0; n < 10; n++) step(0, 0, 1, "hold_grounded", 448, 1'b0);
    step(0, 0, 0, "hold_release", 448, 1'b0);

    // Edge coincident with the tick, plus a discarded second edge at tick 5.
    for (int k = 0; k < 17; k++)
      step(0, 0, (k == 0 || k == 5), "jump_on_tick", prof[k], k < 16);
    for (int n = 0; n < 3; n++) step(0, 0, 0, "after_second_edge", 448, 1'b0);

    // Jump while walking right from x=0.
    for (int k = 0; k < 17; k++)
      tick(tab[k].l, tab[k].r, tab[k].j, "jump_right", tab[k].x, tab[k].y, tab[k].air, tab[k].face);
    ex_x = tab[16].x; ex_face = 1'b0;

    // Without ticks nothing moves, whatever the buttons do.
    for (int n = 0; n < 60; n++) begin
      btn_left  = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      btn_jump  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (n % 20 == 19) begin
        push_exp("no_tick_hold", ex_x, 448, 1'b0, ex_face);
        compare_front();
      end
    end
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    @(posedge clk); #1;
    pulse_jump();

    // Reset coincident with tick 6 of a jump, with a request pending.
    for (int k = 0; k < 6; k++) step(0, 0, 0, "pre_reset_jump", prof[k], 1'b1);
    pulse_jump();
    reset = 1'b1;
    tick(0, 0, 0, "reset_mid_jump", 312, 448, 1'b0, 1'b0);
    reset = 1'b0;
    ex_x = 312; ex_face = 1'b0;
    for (int n = 0; n < 3; n++) step(0, 0, 0, "post_reset_no_req", 448, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
